// File: rtl/oram_frontend.sv
// Path ORAM frontend: on-chip position map, per-access leaf remap, and beat streaming between the user port and the backend.
// CmdOut is valid one cycle after a user command is accepted. Data beats pass through combinationally, so either side can stall.
module oram_frontend #(
  parameter int ORAMU    = 10,
  parameter int ORAML    = 10,
  parameter int ORAMB    = 512,
  parameter int FEDWidth = 64,
  localparam int NB         = ORAMB / FEDWidth,
  localparam int DMWidth    = NB,
  localparam int BECMDWidth = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [BECMDWidth-1:0] CmdIn,
  input  logic [ORAMU-1:0]      ProgAddrIn,
  input  logic [DMWidth-1:0]    WMaskIn,
  input  logic                  CmdInValid,
  output logic                  CmdInReady,
  input  logic [FEDWidth-1:0]   DataIn,
  input  logic                  DataInValid,
  output logic                  DataInReady,
  output logic [FEDWidth-1:0]   ReturnData,
  output logic                  ReturnDataValid,
  input  logic                  ReturnDataReady,
  output logic [BECMDWidth-1:0] CmdOut,
  output logic [ORAMU-1:0]      AddrOut,
  output logic [ORAML-1:0]      OldLeaf,
  output logic [ORAML-1:0]      NewLeaf,
  output logic                  CmdOutValid,
  input  logic                  CmdOutReady,
  output logic [FEDWidth-1:0]   StoreData,
  output logic                  StoreDataValid,
  input  logic                  StoreDataReady,
  input  logic [FEDWidth-1:0]   LoadData,
  input  logic                  LoadDataValid,
  output logic                  LoadDataReady
);

  localparam int DEPTH = 1 << ORAMU;
  localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BECMDWidth-1:0] CMD_APPEND = BECMDWidth'(1);

  typedef enum logic [2:0] {INIT, IDLE, ISSUE, STORE, LOAD} state_e;

  state_e                  state_q, state_d;
  logic [ORAMU-1:0]        init_cnt_q, init_cnt_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [31:0]             lfsr_q, lfsr_d;
  logic [BECMDWidth-1:0]   cmd_q, cmd_d;
  logic [ORAMU-1:0]        addr_q, addr_d;
  logic [DMWidth-1:0]      wmask_q, wmask_d;
  logic [ORAML-1:0]        old_leaf_q, old_leaf_d;
  logic [ORAML-1:0]        new_leaf_q, new_leaf_d;

  logic [ORAML-1:0]        posmap [DEPTH];
  logic                    pm_we;
  logic [ORAMU-1:0]        pm_waddr;
  logic [ORAML-1:0]        pm_wdata;
  logic [31:0]             lfsr_next;
  logic                    store_hs, load_hs;

  assign lfsr_next = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

  assign CmdInReady  = (state_q == IDLE);
  assign CmdOutValid = (state_q == ISSUE);
  assign CmdOut      = cmd_q;
  assign AddrOut     = addr_q;
  assign OldLeaf     = old_leaf_q;
  assign NewLeaf     = new_leaf_q;

  assign StoreDataValid  = (state_q == STORE) && DataInValid;
  assign DataInReady     = (state_q == STORE) && StoreDataReady;
  assign StoreData       = ((state_q == STORE) && wmask_q[beat_q]) ? DataIn : '0;
  assign ReturnDataValid = (state_q == LOAD) && LoadDataValid;
  assign LoadDataReady   = (state_q == LOAD) && ReturnDataReady;
  assign ReturnData      = (state_q == LOAD) ? LoadData : '0;

  assign store_hs = StoreDataValid && StoreDataReady;
  assign load_hs  = ReturnDataValid && ReturnDataReady;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    beat_d     = beat_q;
    lfsr_d     = lfsr_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wmask_d    = wmask_q;
    old_leaf_d = old_leaf_q;
    new_leaf_d = new_leaf_q;
    pm_we      = 1'b0;
    pm_waddr   = init_cnt_q;
    pm_wdata   = '0;
    case (state_q)
      INIT: begin
        pm_we      = 1'b1;
        init_cnt_d = init_cnt_q + ORAMU'(1);
        if (init_cnt_q == ORAMU'(DEPTH - 1)) state_d = IDLE;
      end
      IDLE: begin
        beat_d = '0;
        if (CmdInValid) begin
          cmd_d      = CmdIn;
          addr_d     = ProgAddrIn;
          wmask_d    = WMaskIn;
          lfsr_d     = lfsr_next;
          new_leaf_d = lfsr_next[ORAML-1:0];
          // An appended block has no prior location, so the backend sees the new leaf on both fields.
          old_leaf_d = (CmdIn == CMD_APPEND) ? lfsr_next[ORAML-1:0] : posmap[ProgAddrIn];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (CmdOutReady) begin
          pm_we    = 1'b1;
          pm_waddr = addr_q;
          pm_wdata = new_leaf_q;
          state_d  = cmd_q[1] ? LOAD : STORE;
        end
      end
      STORE: begin
        if (store_hs) begin
          beat_d = beat_q + BW'(1);
          if (beat_q == BW'(NB - 1)) state_d = IDLE;
        end
      end
      LOAD: begin
        if (load_hs) begin
          beat_d = beat_q + BW'(1);
          if (beat_q == BW'(NB - 1)) state_d = IDLE;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      beat_q     <= '0;
      lfsr_q     <= 32'h1;
      cmd_q      <= '0;
      addr_q     <= '0;
      wmask_q    <= '0;
      old_leaf_q <= '0;
      new_leaf_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      beat_q     <= beat_d;
      lfsr_q     <= lfsr_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wmask_q    <= wmask_d;
      old_leaf_q <= old_leaf_d;
      new_leaf_q <= new_leaf_d;
    end
  end

  // Position map is not reset; INIT sweeps it to zero after every reset.
  always_ff @(posedge Clock) begin
    if (pm_we) posmap[pm_waddr] <= pm_wdata;
  end

endmodule

// File: tb/tb_oram_frontend.sv
// Bench for oram_frontend with a 16-entry position map: directed vector table, random transactions, and a reset-mid-store sequence.
module tb_oram_frontend;

  localparam int U  = 4;
  localparam int L  = 10;
  localparam int B  = 512;
  localparam int W  = 64;
  localparam int NB = B / W;
  localparam logic [1:0] UPD = 2'd0, APP = 2'd1, RD = 2'd2, RDR = 2'd3;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic [1:0]    CmdIn = '0;
  logic [U-1:0]  ProgAddrIn = '0;
  logic [NB-1:0] WMaskIn = '0;
  logic          CmdInValid = 1'b0;
  logic          CmdInReady;
  logic [W-1:0]  DataIn = '0;
  logic          DataInValid = 1'b0;
  logic          DataInReady;
  logic [W-1:0]  ReturnData;
  logic          ReturnDataValid;
  logic          ReturnDataReady = 1'b0;
  logic [1:0]    CmdOut;
  logic [U-1:0]  AddrOut;
  logic [L-1:0]  OldLeaf, NewLeaf;
  logic          CmdOutValid;
  logic          CmdOutReady = 1'b0;
  logic [W-1:0]  StoreData;
  logic          StoreDataValid;
  logic          StoreDataReady = 1'b0;
  logic [W-1:0]  LoadData = '0;
  logic          LoadDataValid = 1'b0;
  logic          LoadDataReady;

  oram_frontend #(.ORAMU(U), .ORAML(L), .ORAMB(B), .FEDWidth(W)) dut (
    .Clock(clk), .Reset(Reset),
    .CmdIn(CmdIn), .ProgAddrIn(ProgAddrIn), .WMaskIn(WMaskIn),
    .CmdInValid(CmdInValid), .CmdInReady(CmdInReady),
    .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
    .ReturnData(ReturnData), .ReturnDataValid(ReturnDataValid), .ReturnDataReady(ReturnDataReady),
    .CmdOut(CmdOut), .AddrOut(AddrOut), .OldLeaf(OldLeaf), .NewLeaf(NewLeaf),
    .CmdOutValid(CmdOutValid), .CmdOutReady(CmdOutReady),
    .StoreData(StoreData), .StoreDataValid(StoreDataValid), .StoreDataReady(StoreDataReady),
    .LoadData(LoadData), .LoadDataValid(LoadDataValid), .LoadDataReady(LoadDataReady)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Transaction-level reference: address -> leaf table plus the leaf generator.
  logic [L-1:0] pm_m [1 << U];
  logic [31:0]  lfsr_m;
  logic [W-1:0] beat_dat [NB];

  typedef struct {
    logic [1:0]    cmd;
    logic [U-1:0]  addr;
    logic [NB-1:0] mask;
    int            stall;
    int            rmode;
    logic [L-1:0]  exp_old;
    logic [L-1:0]  exp_new;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    lfsr_m = 32'h1;
    foreach (pm_m[i]) pm_m[i] = '0;
  endtask

  task automatic model_access(input logic [1:0] cmd, input logic [U-1:0] a,
                              output logic [L-1:0] old_l, output logic [L-1:0] new_l);
    lfsr_m = {lfsr_m[30:0], lfsr_m[31] ^ lfsr_m[21] ^ lfsr_m[1] ^ lfsr_m[0]};
    new_l  = lfsr_m[L-1:0];
    old_l  = (cmd == APP) ? new_l : pm_m[a];
    pm_m[a] = new_l;
  endtask

  function automatic logic rdy_pattern(input int rmode, input int cyc);
    if (rmode == 0) return 1'b1;
    if (rmode == 1) return (cyc % 2) == 1;
    return $urandom_range(1) == 1;
  endfunction

  // Entered and left at posedge+1; all sampling happens at negedge.
  task automatic do_reset();
    int zeros = 0;
    Reset = 1'b1;
    CmdInValid = 1'b1; DataInValid = 1'b1; StoreDataReady = 1'b1;
    LoadDataValid = 1'b1; ReturnDataReady = 1'b1; CmdOutReady = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_outs", 64'({CmdInReady, CmdOutValid, StoreDataValid, DataInReady, ReturnDataValid,
                           LoadDataReady, CmdOut, AddrOut, OldLeaf, NewLeaf}), 64'(0));
    CmdInValid = 1'b0; DataInValid = 1'b0; StoreDataReady = 1'b0;
    LoadDataValid = 1'b0; ReturnDataReady = 1'b0; CmdOutReady = 1'b0;
    @(posedge clk); #1;
    Reset = 1'b0;
    @(negedge clk);
    while (!CmdInReady && zeros < 100) begin
      zeros++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("init_cycles", 64'(zeros), 64'(16));
    chk("ready_after_init", 64'(CmdInReady), 64'(1));
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic send_cmd(input logic [1:0] cmd, input logic [U-1:0] a, input logic [NB-1:0] m,
                          input int stall, input logic [L-1:0] exp_old, input logic [L-1:0] exp_new);
    int n = 0;
    logic [27:0] exp_v;
    CmdInValid = 1'b1; CmdIn = cmd; ProgAddrIn = a; WMaskIn = m;
    @(negedge clk);
    while (!CmdInReady && n < 100) begin
      n++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("cmd_in_ready", 64'(CmdInReady), 64'(1));
    @(posedge clk); #1;
    CmdInValid = 1'b0; CmdIn = 2'($urandom); ProgAddrIn = U'($urandom); WMaskIn = NB'($urandom);
    exp_v = {1'b1, 1'b0, cmd, a, exp_old, exp_new};
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("cmd_out_hold", 64'({CmdOutValid, CmdInReady, CmdOut, AddrOut, OldLeaf, NewLeaf}), 64'(exp_v));
      @(posedge clk); #1;
    end
    CmdOutReady = 1'b1;
    @(negedge clk);
    chk("cmd_out", 64'({CmdOutValid, CmdInReady, CmdOut, AddrOut, OldLeaf, NewLeaf}), 64'(exp_v));
    @(posedge clk); #1;
    CmdOutReady = 1'b0;
  endtask

  task automatic store_phase(input logic [NB-1:0] m, input int rmode);
    int   idx = 0;
    int   cyc = 0;
    logic hold = 1'b0;
    while (idx < NB && cyc < 400) begin
      DataInValid    = hold || ($urandom_range(3) != 0);
      DataIn         = beat_dat[idx];
      StoreDataReady = rdy_pattern(rmode, cyc);
      @(negedge clk);
      if (DataInValid && StoreDataReady) begin
        chk("store_hs", 64'({StoreDataValid, DataInReady}), 64'(2'b11));
        chk("store_dat", StoreData, m[idx] ? beat_dat[idx] : 64'd0);
        idx++;
        hold = 1'b0;
      end else begin
        hold = DataInValid;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("store_beats", 64'(idx), 64'(NB));
    DataInValid = 1'b1; StoreDataReady = 1'b1; DataIn = '1;
    @(negedge clk);
    chk("store_done", 64'({CmdInReady, StoreDataValid, DataInReady}), 64'(3'b100));
    @(posedge clk); #1;
    DataInValid = 1'b0; StoreDataReady = 1'b0;
  endtask

  task automatic load_phase(input int rmode);
    int   idx = 0;
    int   cyc = 0;
    logic hold = 1'b0;
    foreach (beat_dat[i]) beat_dat[i] = {$urandom, $urandom};
    while (idx < NB && cyc < 400) begin
      LoadDataValid   = hold || ($urandom_range(3) != 0);
      LoadData        = beat_dat[idx];
      ReturnDataReady = rdy_pattern(rmode, cyc);
      @(negedge clk);
      if (LoadDataValid && ReturnDataReady) begin
        chk("load_hs", 64'({ReturnDataValid, LoadDataReady}), 64'(2'b11));
        chk("ret_dat", ReturnData, beat_dat[idx]);
        idx++;
        hold = 1'b0;
      end else begin
        hold = LoadDataValid;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("load_beats", 64'(idx), 64'(NB));
    LoadDataValid = 1'b1; ReturnDataReady = 1'b1;
    @(negedge clk);
    chk("load_done", 64'({CmdInReady, ReturnDataValid, LoadDataReady}), 64'(3'b100));
    @(posedge clk); #1;
    LoadDataValid = 1'b0; ReturnDataReady = 1'b0;
  endtask

  task automatic run_txn(input logic [1:0] cmd, input logic [U-1:0] a, input logic [NB-1:0] m,
                         input int stall, input int rmode, input logic [L-1:0] exp_old,
                         input logic [L-1:0] exp_new, input logic seq_data);
    send_cmd(cmd, a, m, stall, exp_old, exp_new);
    if (cmd[1]) begin
      load_phase(rmode);
    end else begin
      foreach (beat_dat[i]) beat_dat[i] = seq_data ? 64'(i + 1) : {$urandom, $urandom};
      store_phase(m, rmode);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs [6];
    logic [L-1:0] mo, mn;
    logic [1:0]   rc;
    logic [U-1:0] ra;

    // Leaves follow the generator sequence 3, 6, 0xD, 0x1B, 0x36, 0x6D from reset.
    vecs[0] = '{RD,  4'd3, 8'h00, 0, 0, 10'h000, 10'h003};
    vecs[1] = '{APP, 4'd5, 8'hFF, 2, 2, 10'h006, 10'h006};
    vecs[2] = '{RD,  4'd5, 8'h00, 0, 2, 10'h006, 10'h00D};
    vecs[3] = '{UPD, 4'd7, 8'h05, 5, 1, 10'h000, 10'h01B};
    vecs[4] = '{RD,  4'd7, 8'h00, 1, 1, 10'h01B, 10'h036};
    vecs[5] = '{RDR, 4'd3, 8'h00, 0, 0, 10'h003, 10'h06D};

    do_reset();

    for (int i = 0; i < 6; i++) begin
      model_access(vecs[i].cmd, vecs[i].addr, mo, mn);
      run_txn(vecs[i].cmd, vecs[i].addr, vecs[i].mask, vecs[i].stall, vecs[i].rmode,
              vecs[i].exp_old, vecs[i].exp_new, 1'b1);
    end

    for (int i = 0; i < 40; i++) begin
      rc = 2'($urandom);
      ra = U'($urandom);
      model_access(rc, ra, mo, mn);
      run_txn(rc, ra, NB'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), mo, mn, 1'b0);
    end

    // Abort an Update at beat 3, then confirm the map and generator restarted.
    model_access(UPD, 4'd9, mo, mn);
    send_cmd(UPD, 4'd9, 8'hFF, 0, mo, mn);
    DataInValid = 1'b1; StoreDataReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      DataIn = 64'(i + 1);
      @(negedge clk);
      @(posedge clk); #1;
    end
    do_reset();
    model_access(RD, 4'd9, mo, mn);
    run_txn(RD, 4'd9, 8'h00, 0, 0, 10'h000, 10'h003, 1'b0);
    model_access(RD, 4'd9, mo, mn);
    run_txn(RD, 4'd9, 8'h00, 1, 2, mo, mn, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
